ysyx_22040759_icache: RTL



---
 rtl/ysyx_22040759_icache_pkg.sv | 28 ++
 rtl/ysyx_22040759_icache_array.sv | 53 +++++
 rtl/ysyx_22040759_icache.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22040759_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// line geometry and the default cacheable-region base.
package ysyx_22040759_icache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_LOOKUP = 2'd1,
    IC_MISS   = 2'd2,
    IC_RESP   = 2'd3
  } ic_state_e;

  localparam int          IC_OFFSET_WIDTH = 3;
  localparam int          IC_LINE_BITS    = 64;
  localparam logic [31:0] IC_CACHE_BASE   = 32'h8000_0000;

  // Pick one 32-bit instruction out of an 8-byte line.
  function automatic logic [31:0] ic_word_sel(input logic [IC_LINE_BITS-1:0] line,
                                              input logic hi);
    logic [31:0] word;
    if (hi) begin
      word = line[63:32];
    end else begin
      word = line[31:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/ysyx_22040759_icache_array.sv
// Valid/tag/data storage for the icache: asynchronous read by index,
// one-line synchronous write, and a single-edge clear of every valid bit.
module ysyx_22040759_icache_array
  import ysyx_22040759_icache_pkg::*;
#(
  parameter int IDX_WIDTH = 6,
  parameter int TAG_WIDTH = 23
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_all,
  input  logic                    wr_en,
  input  logic [IDX_WIDTH-1:0]    wr_idx,
  input  logic [TAG_WIDTH-1:0]    wr_tag,
  input  logic [IC_LINE_BITS-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0]    rd_idx,
  output logic                    rd_valid,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [IC_LINE_BITS-1:0] rd_data
);

  localparam int SETS = 1 << IDX_WIDTH;

  logic [SETS-1:0]         valid;
  logic [TAG_WIDTH-1:0]    tag_mem  [SETS];
  logic [IC_LINE_BITS-1:0] data_mem [SETS];

  // Valid bits: flush has priority over a simultaneous install.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= {SETS{1'b0}};
    end else if (flush_all) begin
      valid <= {SETS{1'b0}};
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  // Tag and data payload carry no reset; valid alone qualifies them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/ysyx_22040759_icache.sv
// Direct-mapped read-only instruction cache between IF and the AXI bridge.
// One request in flight; misses fetch a single 64-bit line.
module ysyx_22040759_icache
  import ysyx_22040759_icache_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    IDX_WIDTH  = 6,
  parameter logic [ADDR_WIDTH-1:0] CACHE_BASE = ADDR_WIDTH'(IC_CACHE_BASE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] if_req_addr_i,
  output logic                  if_req_ready_o,
  output logic                  if_rsp_valid_o,
  output logic [31:0]           if_rsp_inst_o,
  input  logic                  fence_i_i,
  output logic                  icache_addr_valid_o,
  output logic [ADDR_WIDTH-1:0] icache_rd_addr_o,
  input  logic                  icache_data_valid_i,
  input  logic [63:0]           icache_data_i
);

  localparam int TAG_WIDTH = ADDR_WIDTH - IDX_WIDTH - IC_OFFSET_WIDTH;

  ic_state_e             state;
  ic_state_e             state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic                  rsp_valid;
  logic [31:0]           inst;
  logic                  addr_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  no_install;

  logic [IDX_WIDTH-1:0]  addr_idx;
  logic [TAG_WIDTH-1:0]  addr_tag;
  logic                  word_hi;
  logic                  cacheable;
  logic                  arr_valid;
  logic [TAG_WIDTH-1:0]  arr_tag;
  logic [63:0]           arr_data;
  logic                  hit;
  logic                  refill_done;
  logic                  install;

  assign addr_idx  = addr[IDX_WIDTH+IC_OFFSET_WIDTH-1:IC_OFFSET_WIDTH];
  assign addr_tag  = addr[ADDR_WIDTH-1:IDX_WIDTH+IC_OFFSET_WIDTH];
  assign word_hi   = addr[IC_OFFSET_WIDTH-1];
  assign cacheable = (addr >= CACHE_BASE);

  // A fence on the lookup edge must make the lookup miss, matching the cleared array.
  assign hit         = arr_valid && (arr_tag == addr_tag) && cacheable && !fence_i_i;
  assign refill_done = (state == IC_MISS) && icache_data_valid_i;
  assign install     = refill_done && cacheable && !no_install && !fence_i_i;

  ysyx_22040759_icache_array #(
    .IDX_WIDTH (IDX_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .flush_all (fence_i_i),
    .wr_en     (install),
    .wr_idx    (addr_idx),
    .wr_tag    (addr_tag),
    .wr_data   (icache_data_i),
    .rd_idx    (addr_idx),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data)
  );

  // Next-state selection for the fetch FSM.
  always_comb begin
    state_next = state;
    case (state)
      IC_IDLE: begin
        if (if_req_valid_i) begin
          state_next = IC_LOOKUP;
        end else begin
          state_next = IC_IDLE;
        end
      end
      IC_LOOKUP: begin
        if (hit) begin
          state_next = IC_RESP;
        end else begin
          state_next = IC_MISS;
        end
      end
      IC_MISS: begin
        if (icache_data_valid_i) begin
          state_next = IC_RESP;
        end else begin
          state_next = IC_MISS;
        end
      end
      IC_RESP:  state_next = IC_IDLE;
      default:  state_next = IC_IDLE;
    endcase
  end

  // State, request address, registered outputs and the per-miss no-install flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IC_IDLE;
      addr       <= {ADDR_WIDTH{1'b0}};
      ready      <= 1'b1;
      rsp_valid  <= 1'b0;
      inst       <= 32'h0;
      addr_valid <= 1'b0;
      rd_addr    <= {ADDR_WIDTH{1'b0}};
      no_install <= 1'b0;
    end else begin
      state     <= state_next;
      ready     <= (state_next == IC_IDLE);
      rsp_valid <= (state_next == IC_RESP);

      if ((state == IC_IDLE) && if_req_valid_i) begin
        addr <= if_req_addr_i;
      end

      if ((state == IC_LOOKUP) && hit) begin
        inst <= ic_word_sel(arr_data, word_hi);
      end else if (refill_done) begin
        inst <= ic_word_sel(icache_data_i, word_hi);
      end

      if ((state == IC_LOOKUP) && !hit) begin
        addr_valid <= 1'b1;
        rd_addr    <= {addr[ADDR_WIDTH-1:IC_OFFSET_WIDTH], {IC_OFFSET_WIDTH{1'b0}}};
      end else if (refill_done) begin
        addr_valid <= 1'b0;
      end

      if (state == IC_LOOKUP) begin
        no_install <= 1'b0;
      end else if ((state == IC_MISS) && fence_i_i) begin
        no_install <= 1'b1;
      end
    end
  end

  assign if_req_ready_o      = ready;
  assign if_rsp_valid_o      = rsp_valid;
  assign if_rsp_inst_o       = inst;
  assign icache_addr_valid_o = addr_valid;
  assign icache_rd_addr_o    = rd_addr;

endmodule
